// File: rtl/hazard_unit_if.sv
// ID-stage hazard control bundle: IF/ID instruction and start in, pipeline enables and debug counters out.
// Latency: n/a (wires only).
// Backpressure: pc_write_o/ifid_write_o are the stall handshake back to fetch.
interface hazard_unit_if #(
    parameter int CNT_W = 16
) ();
    logic             start_i;
    logic [31:0]      inst_i;
    logic             branch_taken_i;
    logic             noop_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output start_i, inst_i, branch_taken_i,
        input  noop_o, pc_write_o, ifid_write_o, flush_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  start_i, inst_i, branch_taken_i,
        output noop_o, pc_write_o, ifid_write_o, flush_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_unit.sv
// ID-stage load-use / branch-operand stall and taken-branch flush controller with saturating debug counters.
// Latency: control outputs are same-cycle (Mealy on inst_i); counters follow one edge later.
// Backpressure: a stall drops pc_write_o/ifid_write_o so IF/ID holds inst_i until the hazard clears.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } shadow_t;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam shadow_t    BUBBLE    = '0;

    state_t           state;
    shadow_t          ex_q;
    shadow_t          mem_q;
    shadow_t          dec;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       is_branch;
    logic       hit_ex;
    logic       hit_mem;
    logic       run;
    logic       stall;
    logic       flush;
    logic       unused_inst;

    assign op          = bus.inst_i[6:0];
    assign rs1         = bus.inst_i[19:15];
    assign rs2         = bus.inst_i[24:20];
    assign unused_inst = ^{bus.inst_i[31:25], bus.inst_i[14:12]};

    always_comb begin
        dec     = BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (op)
            OP_ALU: begin
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_ALUI: begin
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                use_rs1      = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
        if (dec.regwrite) begin
            dec.rd = bus.inst_i[11:7];
        end
    end

    assign hit_ex  = ex_q.regwrite && (ex_q.rd != 5'd0) &&
                     ((use_rs1 && (ex_q.rd == rs1)) || (use_rs2 && (ex_q.rd == rs2)));
    assign hit_mem = mem_q.regwrite && (mem_q.rd != 5'd0) &&
                     ((use_rs1 && (mem_q.rd == rs1)) || (use_rs2 && (mem_q.rd == rs2)));

    // beq resolves in ID, so it waits for ALU results in EX and load data still in MEM.
    assign is_branch = (op == OP_BRANCH);
    assign run       = (state == RUN);
    assign stall     = run && ((ex_q.memread && hit_ex) ||
                               (is_branch && (hit_ex || (hit_mem && mem_q.memread))));
    assign flush     = run && !stall && is_branch && bus.branch_taken_i;

    assign bus.noop_o       = !run || stall;
    assign bus.pc_write_o   = run && !stall;
    assign bus.ifid_write_o = run && !stall;
    assign bus.flush_o      = flush;
    assign bus.stall_cnt_o  = stall_cnt;
    assign bus.flush_cnt_o  = flush_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            ex_q      <= BUBBLE;
            mem_q     <= BUBBLE;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == IDLE) begin
            if (bus.start_i) begin
                state <= RUN;
            end
        end else begin
            mem_q <= ex_q;
            ex_q  <= stall ? BUBBLE : dec;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

ID-stage hazard and flush controller for the 5-stage pipelined CPU. Decodes the IF/ID instruction word and keeps its own shadow copy of the destination register and load/write flags of the instructions in EX and MEM. From these it generates the `noop` request into the main decoder, the PC and IF/ID write enables, and the IF/ID flush for taken branches. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  leave IDLE and start issuing (sampled each cycle in IDLE)
- inst_i  in  32  instruction word currently held in IF/ID
- branch_taken_i  in  1  ID-stage beq comparator result for inst_i
- noop_o  out  1  to main decoder: force all control bits to 0 (bubble into ID/EX)
- pc_write_o  out  1  PC register write enable
- ifid_write_o  out  1  IF/ID register write enable
- flush_o  out  1  clear IF/ID at next edge (taken branch)
- stall_cnt_o  out  CNT_W  bubbles inserted since reset
- flush_cnt_o  out  CNT_W  flushes issued since reset

## Operation
- Field extraction from inst_i: op=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- Class: regwrite for op 0110011 (add), 0010011 (addi), 0000011 (lw). memread only for 0000011. Uses rs2: 0110011, 0100011 (sw), 1100011 (beq). Uses rs1: all of those plus 0010011 and 0000011. Op 0000000 is a nop: no reads, no writes.
- Shadow registers: ex_{rd,regwrite,memread} and mem_{rd,regwrite,memread}. A bubble entry has rd=0 and both flags 0.
- A match for register r against stage s means s_regwrite=1, s_rd!=0, s_rd==r, and inst_i actually uses r.
- Stall conditions, evaluated only in RUN, combinational from shadow state and inst_i:
  - load-use: ex_memread and a match against EX.
  - branch-operand (op==1100011 only): a match against EX (any regwrite), or a match against MEM with mem_memread=1.
- Result: lw followed directly by a dependent beq gives 2 bubbles. An ALU op followed by a dependent beq gives 1 bubble. lw followed by a dependent ALU op, sw or lw gives 1 bubble.
- FSM states:
  - IDLE: noop_o=1, pc_write_o=0, ifid_write_o=0, flush_o=0, shadows hold bubbles. IDLE→RUN on start_i=1.
  - RUN: on a stall, noop_o=1, pc_write_o=0, ifid_write_o=0, flush_o=0. Otherwise noop_o=0, pc_write_o=1, ifid_write_o=1, and flush_o=branch_taken_i & (op==1100011).
  - No return to IDLE except by reset.
- Shadow update each edge in RUN: mem←ex; ex←bubble if stall, else the decode of inst_i.
- Stall beats branch: branch_taken_i is ignored while a stall is asserted, because the operands are not valid yet.
- Counters: stall_cnt +1 per stalled RUN cycle; flush_cnt +1 per cycle with flush_o=1. Both saturate at all-ones and never wrap.

## Timing
- Reset (rst_i=0 at an edge): state=IDLE, shadows=bubble, counters=0. Outputs after that edge: noop_o=1, pc_write_o=0, ifid_write_o=0, flush_o=0, stall_cnt_o=0, flush_cnt_o=0. Reset overrides any in-progress stall or flush.
- All control outputs are Mealy: valid in the same cycle as inst_i, with zero-cycle latency, from registered state.
- While stalled, inst_i is held by the IF/ID register, so the condition is re-evaluated every cycle. A 2-bubble stall is two consecutive stalled cycles with no extra state.
- flush_o is high for exactly one cycle per taken beq. In the next cycle, inst_i is the zeroed IF/ID (nop) and produces no stall.
- Counter outputs are registered and reflect the event one edge later.
- start_i and branch_taken_i are don't-care in states or cycles where they are not sampled.

## Test plan
- Reset and start: hold rst_i=0 for 2 cycles, then release with start_i=0 → noop_o=1, pc_write_o=0, counters 0. Pulse start_i → next cycle noop_o=0, pc_write_o=1.
- Load-use: issue lw x5,0(x1) then add x6,x5,x2 → exactly 1 cycle with noop_o=1, pc_write_o=0, ifid_write_o=0, then the add proceeds; stall_cnt_o=1. The same sequence with lw x0 and add x6,x0,x2 → no stall.
- Branch operands: add x7,x1,x2 then beq x7,x0 → 1 bubble. lw x7 then beq x7,x0 → 2 consecutive bubbles. addi x7 then beq x8,x9 → 0 bubbles.
- Flush: beq with no hazard and branch_taken_i=1 → flush_o=1 for one cycle, flush_cnt_o=1. lw x7; beq x7,x0 with branch_taken_i=1 held throughout → flush only in the third cycle, after the 2 bubbles.
- Reset mid-stall: assert rst_i=0 during the first bubble of the lw/beq case → IDLE outputs and zero counters after the edge; after restart, beq with no producer ahead of it → no stall.
- Saturation: with CNT_W=2, issue 5 load-use pairs → stall_cnt_o stops at 3.
